// File: rtl/frame_chk_pkg.sv
// Shared definitions for the frame geometry checker: default widths, FSM encoding and
// the saturating increment used by every non-wrapping counter.
package frame_chk_pkg;

   localparam int unsigned CNT_WD_DEF = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFrame = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Counters up to 32 bits are zero-extended in; callers truncate the result back.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      return (val == max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/edge_det.sv
// One-cycle delay of a 1-bit strobe with rise/fall detection against the delayed copy.
module edge_det #(
   parameter logic RstVal = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic q_q, q_d;

   always_comb begin
      q_d = i_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= RstVal;
      end else begin
         q_q <= q_d;
      end
   end

   assign o_q    = q_q;
   assign o_rise = i_d & ~q_q;
   assign o_fall = ~i_d & q_q;

endmodule

// File: rtl/frame_size_chk.sv
// Counts lines per frame and pixels per line on the fval/lval stream, compares them against
// the configured geometry and publishes per-frame results plus frame/error-frame counters.
module frame_size_chk
   import frame_chk_pkg::*;
#(
   parameter int unsigned REG_WD = 32,
   parameter int unsigned CNT_WD = CNT_WD_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_fval,
   input  logic              i_lval,
   input  logic              i_chk_en,
   input  logic [CNT_WD-1:0] iv_width,
   input  logic [CNT_WD-1:0] iv_height,
   output logic              o_frame_done,
   output logic [CNT_WD-1:0] ov_line_cnt,
   output logic [CNT_WD-1:0] ov_last_pix_cnt,
   output logic              o_err_width,
   output logic              o_err_height,
   output logic              o_err_lval,
   output logic [REG_WD-1:0] ov_frame_cnt,
   output logic [REG_WD-1:0] ov_err_frame_cnt
);

   localparam logic [CNT_WD-1:0] CntMax = '1;
   localparam logic [REG_WD-1:0] RegMax = '1;

   logic fval_dly, fval_rise, fval_fall;
   logic lval_dly, lval_rise, lval_fall;

   // fval delay resets high so a frame already in progress at reset release is skipped.
   edge_det #(.RstVal(1'b1)) u_fval_edge (
      .clk    (clk),
      .reset  (reset),
      .i_d    (i_fval),
      .o_q    (fval_dly),
      .o_rise (fval_rise),
      .o_fall (fval_fall)
   );

   edge_det #(.RstVal(1'b0)) u_lval_edge (
      .clk    (clk),
      .reset  (reset),
      .i_d    (i_lval),
      .o_q    (lval_dly),
      .o_rise (lval_rise),
      .o_fall (lval_fall)
   );

   state_e            state_q, state_d;
   logic [CNT_WD-1:0] width_q, width_d;
   logic [CNT_WD-1:0] height_q, height_d;
   logic [CNT_WD-1:0] pix_cnt_q, pix_cnt_d;
   logic [CNT_WD-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_WD-1:0] lpix_q, lpix_d;
   logic              werr_q, werr_d;

   logic              frame_done_q, frame_done_d;
   logic [CNT_WD-1:0] line_out_q, line_out_d;
   logic [CNT_WD-1:0] last_pix_q, last_pix_d;
   logic              err_width_q, err_width_d;
   logic              err_height_q, err_height_d;
   logic              err_lval_q, err_lval_d;
   logic [REG_WD-1:0] frame_cnt_q, frame_cnt_d;
   logic [REG_WD-1:0] err_frame_cnt_q, err_frame_cnt_d;

   logic              line_close;
   logic [CNT_WD-1:0] line_nxt, lpix_nxt;
   logic              werr_nxt, herr;

   always_comb begin
      state_d         = state_q;
      width_d         = width_q;
      height_d        = height_q;
      pix_cnt_d       = pix_cnt_q;
      line_cnt_d      = line_cnt_q;
      lpix_d          = lpix_q;
      werr_d          = werr_q;
      frame_done_d    = 1'b0;
      line_out_d      = line_out_q;
      last_pix_d      = last_pix_q;
      err_width_d     = err_width_q;
      err_height_d    = err_height_q;
      err_lval_d      = i_chk_en & i_lval & ~i_fval;
      frame_cnt_d     = frame_cnt_q;
      err_frame_cnt_d = err_frame_cnt_q;

      // A line also closes when fval drops underneath a still-high lval.
      line_close = lval_fall | (fval_dly & ~i_fval & lval_dly & i_lval);
      line_nxt   = line_close ? CNT_WD'(sat_inc(32'(line_cnt_q), 32'(CntMax))) : line_cnt_q;
      lpix_nxt   = line_close ? pix_cnt_q : lpix_q;
      werr_nxt   = werr_q | (line_close & (pix_cnt_q != width_q));
      herr       = (line_nxt != height_q);

      unique case (state_q)
         StFrame: begin
            if (i_fval & i_lval) begin
               pix_cnt_d = lval_rise ? CNT_WD'(1) :
                           CNT_WD'(sat_inc(32'(pix_cnt_q), 32'(CntMax)));
            end else if (line_close) begin
               pix_cnt_d = '0;
            end
            line_cnt_d = line_nxt;
            lpix_d     = lpix_nxt;
            werr_d     = werr_nxt;
            if (fval_fall) begin
               state_d      = StDone;
               frame_done_d = 1'b1;
               line_out_d   = line_nxt;
               last_pix_d   = lpix_nxt;
               err_width_d  = i_chk_en & werr_nxt;
               err_height_d = i_chk_en & herr;
               frame_cnt_d  = frame_cnt_q + REG_WD'(1);
               if (i_chk_en & (werr_nxt | herr)) begin
                  err_frame_cnt_d = REG_WD'(sat_inc(32'(err_frame_cnt_q), 32'(RegMax)));
               end
            end
         end
         StIdle, StDone: begin
            if (state_q == StDone) begin
               state_d = StIdle;
            end
            if (fval_rise) begin
               state_d    = StFrame;
               width_d    = iv_width;
               height_d   = iv_height;
               pix_cnt_d  = i_lval ? CNT_WD'(1) : '0;
               line_cnt_d = '0;
               lpix_d     = '0;
               werr_d     = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         width_q         <= '0;
         height_q        <= '0;
         pix_cnt_q       <= '0;
         line_cnt_q      <= '0;
         lpix_q          <= '0;
         werr_q          <= 1'b0;
         frame_done_q    <= 1'b0;
         line_out_q      <= '0;
         last_pix_q      <= '0;
         err_width_q     <= 1'b0;
         err_height_q    <= 1'b0;
         err_lval_q      <= 1'b0;
         frame_cnt_q     <= '0;
         err_frame_cnt_q <= '0;
      end else begin
         state_q         <= state_d;
         width_q         <= width_d;
         height_q        <= height_d;
         pix_cnt_q       <= pix_cnt_d;
         line_cnt_q      <= line_cnt_d;
         lpix_q          <= lpix_d;
         werr_q          <= werr_d;
         frame_done_q    <= frame_done_d;
         line_out_q      <= line_out_d;
         last_pix_q      <= last_pix_d;
         err_width_q     <= err_width_d;
         err_height_q    <= err_height_d;
         err_lval_q      <= err_lval_d;
         frame_cnt_q     <= frame_cnt_d;
         err_frame_cnt_q <= err_frame_cnt_d;
      end
   end

   assign o_frame_done     = frame_done_q;
   assign ov_line_cnt      = line_out_q;
   assign ov_last_pix_cnt  = last_pix_q;
   assign o_err_width      = err_width_q;
   assign o_err_height     = err_height_q;
   assign o_err_lval       = err_lval_q;
   assign ov_frame_cnt     = frame_cnt_q;
   assign ov_err_frame_cnt = err_frame_cnt_q;

endmodule

// File: tb/tb_frame_size_chk.sv
// Directed frames drive frame_size_chk; expected per-frame results are queued at stimulus
// time and popped by a monitor whenever o_frame_done is seen.
module tb_frame_size_chk;

   localparam int unsigned REG_WD = 32;
   localparam int unsigned CNT_WD = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              i_fval = 1'b0;
   logic              i_lval = 1'b0;
   logic              i_chk_en = 1'b1;
   logic [CNT_WD-1:0] iv_width = 16'd64;
   logic [CNT_WD-1:0] iv_height = 16'd64;
   logic              o_frame_done;
   logic [CNT_WD-1:0] ov_line_cnt;
   logic [CNT_WD-1:0] ov_last_pix_cnt;
   logic              o_err_width;
   logic              o_err_height;
   logic              o_err_lval;
   logic [REG_WD-1:0] ov_frame_cnt;
   logic [REG_WD-1:0] ov_err_frame_cnt;

   frame_size_chk #(.REG_WD(REG_WD), .CNT_WD(CNT_WD)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_fval           (i_fval),
      .i_lval           (i_lval),
      .i_chk_en         (i_chk_en),
      .iv_width         (iv_width),
      .iv_height        (iv_height),
      .o_frame_done     (o_frame_done),
      .ov_line_cnt      (ov_line_cnt),
      .ov_last_pix_cnt  (ov_last_pix_cnt),
      .o_err_width      (o_err_width),
      .o_err_height     (o_err_height),
      .o_err_lval       (o_err_lval),
      .ov_frame_cnt     (ov_frame_cnt),
      .ov_err_frame_cnt (ov_err_frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint lc;
      longint lp;
      longint ew;
      longint eh;
      longint fc;
      longint efc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   exp_fc = 0;
   int   exp_efc = 0;
   int   exp_lval = 0;
   int   got_lval = 0;

   task automatic chk(input string name, input longint got, input longint want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (o_err_lval) got_lval++;
      if (o_frame_done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("line_cnt", ov_line_cnt, e.lc);
            chk("last_pix_cnt", ov_last_pix_cnt, e.lp);
            chk("err_width", o_err_width, e.ew);
            chk("err_height", o_err_height, e.eh);
            chk("frame_cnt", ov_frame_cnt, e.fc);
            chk("err_frame_cnt", ov_err_frame_cnt, e.efc);
         end
      end
   end

   task automatic drv(input bit f, input bit l);
      @(posedge clk);
      #1;
      i_fval = f;
      i_lval = l;
   endtask

   // short_ln < 0 means every line is ppl pixels long.
   task automatic frame(input int nl, input int ppl, input int short_ln, input int short_px,
                        input int w, input int h, input bit coinc, input int gap);
      exp_t e;
      int   n;
      bit   werr;
      werr = 1'b0;
      for (int ln = 0; ln < nl; ln++) begin
         n = (ln == short_ln) ? short_px : ppl;
         if (n != w) werr = 1'b1;
      end
      e.lc = nl;
      e.lp = (nl == 0) ? 0 : (((nl - 1) == short_ln) ? short_px : ppl);
      e.ew = i_chk_en & werr;
      e.eh = i_chk_en & (nl != h);
      exp_fc++;
      if (e.ew != 0 || e.eh != 0) exp_efc++;
      e.fc  = exp_fc;
      e.efc = exp_efc;
      exp_q.push_back(e);

      iv_width  = CNT_WD'(w);
      iv_height = CNT_WD'(h);
      repeat ((nl == 0) ? 1 : 2) drv(1, 0);
      for (int ln = 0; ln < nl; ln++) begin
         n = (ln == short_ln) ? short_px : ppl;
         repeat (n) drv(1, 1);
         if (!(coinc && ln == nl - 1)) drv(1, 0);
      end
      if (!coinc) repeat (2) drv(1, 0);
      repeat (gap) drv(0, 0);
   endtask

   task automatic lval_pulse();
      drv(0, 1);
      drv(0, 0);
      if (i_chk_en) exp_lval++;
      repeat (2) drv(0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      chk("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_done", o_frame_done, 0);
      chk("rst_line_cnt", ov_line_cnt, 0);
      chk("rst_last_pix", ov_last_pix_cnt, 0);
      chk("rst_err_width", o_err_width, 0);
      chk("rst_err_height", o_err_height, 0);
      chk("rst_err_lval", o_err_lval, 0);
      chk("rst_frame_cnt", ov_frame_cnt, 0);
      chk("rst_err_frame_cnt", ov_err_frame_cnt, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) drv(0, 0);

      frame(64, 64, -1, 0, 64, 64, 1'b0, 3);   // clean
      frame(64, 64, 10, 63, 64, 64, 1'b0, 3);  // short line 10
      frame(64, 64, -1, 0, 64, 64, 1'b0, 3);   // clean clears err_width
      frame(63, 64, -1, 0, 64, 64, 1'b0, 3);   // one line short
      frame(0, 0, -1, 0, 64, 64, 1'b0, 3);     // 3-cycle fval, no lines
      frame(4, 8, -1, 0, 8, 4, 1'b1, 3);       // fval and lval fall together
      drain();

      lval_pulse();
      chk("lval_hold_frame_cnt", ov_frame_cnt, exp_fc);
      chk("lval_hold_line_cnt", ov_line_cnt, 4);

      i_chk_en = 1'b0;
      frame(3, 8, 1, 5, 8, 4, 1'b0, 3);        // width and height wrong, checking off
      lval_pulse();
      drain();
      i_chk_en = 1'b1;

      // Reset in the middle of line 30, released while fval is still high.
      iv_width  = 16'd64;
      iv_height = 16'd64;
      drv(1, 0);
      for (int ln = 0; ln < 30; ln++) begin
         repeat (64) drv(1, 1);
         drv(1, 0);
      end
      reset = 1'b1;
      repeat (3) drv(1, 1);
      @(negedge clk);
      chk("midrst_done", o_frame_done, 0);
      chk("midrst_frame_cnt", ov_frame_cnt, 0);
      chk("midrst_err_frame_cnt", ov_err_frame_cnt, 0);
      exp_fc  = 0;
      exp_efc = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int ln = 0; ln < 33; ln++) begin
         repeat (64) drv(1, 1);
         drv(1, 0);
      end
      repeat (3) drv(0, 0);
      frame(64, 64, -1, 0, 64, 64, 1'b0, 3);   // reports frame_cnt=1

      for (int i = 0; i < 30; i++) begin
         frame(4, 8, -1, 0, 8, 4, 1'b0, (i % 5 == 0) ? 20 : 1 + (i % 3));
      end
      drain();
      repeat (3) drv(0, 0);
      chk("lval_pulses", got_lval, exp_lval);
      chk("final_frame_cnt", ov_frame_cnt, 31);
      chk("final_err_frame_cnt", ov_err_frame_cnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
